cache_assoc_controller: RTL and testbench

Next-generation cache control FSM for the memory stage, generalised from the direct-mapped controller to N-way set-associative lines of WORDS words.
- Decides hit or miss and selects the victim way round-robin.
- Sequences multi-word dirty write-back and a pipelined line fill against a fixed-latency banked memory.
- Completes the original access.
- Drives only control; the datapath (tag/data arrays, memory, address muxes) is external.

---
 rtl/cache_ctrl_pkg.sv | 27 ++
 rtl/cache_victim_sel.sv | 48 ++++
 rtl/cache_assoc_controller.sv | 243 ++++++++++++++++++++++++
 tb/tb_cache_assoc_controller.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the set-associative cache controller:
// FSM state encoding and the width helpers derived from WAYS/WORDS.
package cache_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WB     = 3'd1,
        FILL   = 3'd2,
        FINISH = 3'd3,
        ERR    = 3'd4
    } state_t;

    localparam int DEF_WAYS    = 2;
    localparam int DEF_WORDS   = 4;
    localparam int DEF_MEM_LAT = 2;

    // Way index width; a direct-mapped build still carries a 1-bit way_sel.
    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // Word offset width within a line.
    function automatic int off_w(input int words);
        return $clog2(words);
    endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Victim way selection: the lowest-index invalid way if there is one,
// otherwise the round-robin pointer. The pointer steps on every miss.
module cache_victim_sel
    import cache_ctrl_pkg::*;
#(
    parameter  int WAYS  = DEF_WAYS,
    localparam int WAY_W = way_w(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WAYS-1:0]  valid,
    input  logic             adv,
    output logic [WAY_W-1:0] victim
);

    generate
        if (WAYS > 1) begin : g_rr
            logic [WAY_W-1:0] rr;
            logic [WAY_W-1:0] inv_idx;
            logic             inv_any;

            // Round-robin pointer, wraps at WAYS-1
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rr <= '0;
                end else if (adv) begin
                    rr <= (rr == WAY_W'(WAYS - 1)) ? '0 : rr + WAY_W'(1);
                end
            end

            // Lowest-index invalid way takes priority over the pointer
            always_comb begin
                inv_any = 1'b0;
                inv_idx = '0;
                for (int i = WAYS - 1; i >= 0; i--) begin
                    if (!valid[i]) begin
                        inv_any = 1'b1;
                        inv_idx = WAY_W'(i);
                    end
                end
                victim = inv_any ? inv_idx : rr;
            end
        end else begin : g_one
            assign victim = '0;
        end
    endgenerate

endmodule

// File: rtl/cache_assoc_controller.sv
// Control FSM for an N-way set-associative cache in the memory stage.
// Decides hit/miss, picks a victim, sequences dirty write-back and a
// pipelined line fill against a fixed-latency memory, then completes the
// original access. Datapath (arrays, memory, address muxes) is external.
// Optional build macro CACHE_PERF_CNT_EN adds saturating hit/miss/write-back
// event counters.
module cache_assoc_controller
    import cache_ctrl_pkg::*;
#(
    parameter  int WAYS    = DEF_WAYS,
    parameter  int WORDS   = DEF_WORDS,
    parameter  int MEM_LAT = DEF_MEM_LAT,
    localparam int WAY_W   = way_w(WAYS),
    localparam int OFF_W   = off_w(WORDS),
    localparam int CNT_W   = OFF_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd,
    input  logic             wr,
    input  logic [WAYS-1:0]  hit,
    input  logic [WAYS-1:0]  valid,
    input  logic [WAYS-1:0]  dirty,
    input  logic             cache_err,
    input  logic             mem_err,
    input  logic             mem_stall,
    output logic             comp,
    output logic             cache_wr,
    output logic [WAY_W-1:0] way_sel,
    output logic [OFF_W-1:0] word_sel,
    output logic             set_valid,
    output logic             use_victim_tag,
    output logic             mem_wr,
    output logic             mem_rd,
    output logic [OFF_W-1:0] mem_word,
    output logic             done,
    output logic             cache_hit,
    output logic             stall,
    output logic             err
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [15:0]      hit_cnt,
    output logic [15:0]      miss_cnt,
    output logic [15:0]      wb_cnt
`endif
);

    state_t           state, nstate;
    logic             op_wr;
    logic [WAY_W-1:0] victim_q;
    logic [WAY_W-1:0] victim_new;
    logic [WAY_W-1:0] hit_way;
    logic             hit_any;
    logic             req;
    logic             any_err;
    logic             miss;
    logic             rd_accept;
    logic             rd_ret;
    logic [CNT_W-1:0] wcnt;
    logic [CNT_W-1:0] icnt;
    logic [CNT_W-1:0] rcnt;
    // Outstanding-read tracker: bit i set means a read accepted i+1 cycles ago
    logic [MEM_LAT-1:0] rd_vld_p;

    assign req       = rd | wr;
    assign any_err   = cache_err | mem_err;
    assign miss      = (state == IDLE) && req && !any_err && !hit_any;
    assign rd_accept = mem_rd && !mem_stall;
    assign rd_ret    = rd_vld_p[MEM_LAT-1];

    cache_victim_sel #(
        .WAYS   (WAYS)
    ) u_victim_sel (
        .clk    (clk),
        .rst    (rst),
        .valid  (valid),
        .adv    (miss),
        .victim (victim_new)
    );

    // Lowest-index way with a valid tag match
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit[i] && valid[i]) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(i);
            end
        end
    end

    // Next-state and control outputs
    always_comb begin
        nstate         = state;
        comp           = 1'b0;
        cache_wr       = 1'b0;
        way_sel        = '0;
        word_sel       = '0;
        set_valid      = 1'b0;
        use_victim_tag = 1'b0;
        mem_wr         = 1'b0;
        mem_rd         = 1'b0;
        mem_word       = '0;
        done           = 1'b0;
        cache_hit      = 1'b0;
        stall          = 1'b1;
        err            = 1'b0;
        case (state)
            IDLE: begin
                stall = 1'b0;
                if (req) begin
                    comp = 1'b1;
                    if (any_err) begin
                        done = 1'b1;
                        err  = 1'b1;
                    end else if (hit_any) begin
                        done      = 1'b1;
                        cache_hit = 1'b1;
                        way_sel   = hit_way;
                        cache_wr  = wr;
                    end else begin
                        nstate = (valid[victim_new] && dirty[victim_new]) ? WB : FILL;
                    end
                end
            end
            WB: begin
                way_sel        = victim_q;
                word_sel       = wcnt[OFF_W-1:0];
                use_victim_tag = 1'b1;
                mem_wr         = 1'b1;
                mem_word       = wcnt[OFF_W-1:0];
                if (!mem_stall && wcnt == CNT_W'(WORDS - 1)) begin
                    nstate = FILL;
                end
            end
            FILL: begin
                way_sel = victim_q;
                if (icnt < CNT_W'(WORDS)) begin
                    mem_rd   = 1'b1;
                    mem_word = icnt[OFF_W-1:0];
                end
                if (rd_ret) begin
                    cache_wr = 1'b1;
                    word_sel = rcnt[OFF_W-1:0];
                    if (rcnt == CNT_W'(WORDS - 1)) begin
                        set_valid = 1'b1;
                        nstate    = FINISH;
                    end
                end
            end
            FINISH: begin
                comp     = 1'b1;
                way_sel  = victim_q;
                cache_wr = op_wr;
                done     = 1'b1;
                stall    = 1'b0;
                nstate   = IDLE;
            end
            ERR: begin
                err    = 1'b1;
                done   = 1'b1;
                nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
        // An error mid-transaction aborts it: no array/memory side effects
        if ((state == WB || state == FILL || state == FINISH) && any_err) begin
            nstate    = ERR;
            cache_wr  = 1'b0;
            set_valid = 1'b0;
            mem_wr    = 1'b0;
            mem_rd    = 1'b0;
            done      = 1'b0;
            stall     = 1'b1;
        end
    end

    // State, latched request and beat counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_wr    <= 1'b0;
            victim_q <= '0;
            wcnt     <= '0;
            icnt     <= '0;
            rcnt     <= '0;
            rd_vld_p <= '0;
        end else begin
            state <= nstate;
            if (miss) begin
                op_wr    <= wr;
                victim_q <= victim_new;
            end
            if (state == IDLE || state == ERR) begin
                wcnt     <= '0;
                icnt     <= '0;
                rcnt     <= '0;
                rd_vld_p <= '0;
            end else begin
                if (mem_wr && !mem_stall) begin
                    wcnt <= (wcnt == CNT_W'(WORDS - 1)) ? '0 : wcnt + CNT_W'(1);
                end
                if (rd_accept) begin
                    icnt <= icnt + CNT_W'(1);
                end
                if (state == FILL && rd_ret) begin
                    rcnt <= rcnt + CNT_W'(1);
                end
                rd_vld_p[0] <= rd_accept;
                for (int i = 1; i < MEM_LAT; i++) begin
                    rd_vld_p[i] <= rd_vld_p[i-1];
                end
            end
        end
    end

`ifdef CACHE_PERF_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Saturating hit / miss / write-back event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            if (done && cache_hit) begin
                hit_cnt <= sat_inc(hit_cnt);
            end
            if (miss) begin
                miss_cnt <= sat_inc(miss_cnt);
            end
            if (state != WB && nstate == WB) begin
                wb_cnt <= sat_inc(wb_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_assoc_controller.sv
// Self-checking bench for cache_assoc_controller (WAYS=2, WORDS=4, MEM_LAT=2).
// Completions are matched against a scoreboard queue of expected results;
// per-cycle control sequences are checked against a cycle model.
module tb_cache_assoc_controller;

    localparam int WAYS    = 2;
    localparam int WORDS   = 4;
    localparam int MEM_LAT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       rd, wr;
    logic [1:0] hit, valid, dirty;
    logic       cache_err, mem_err, mem_stall;
    logic       comp, cache_wr, set_valid, use_victim_tag, mem_wr, mem_rd;
    logic       done, cache_hit, stall, err;
    logic [0:0] way_sel;
    logic [1:0] word_sel, mem_word;
`ifdef CACHE_PERF_CNT_EN
    logic [15:0] hit_cnt, miss_cnt, wb_cnt;
`endif

    cache_assoc_controller #(
        .WAYS           (WAYS),
        .WORDS          (WORDS),
        .MEM_LAT        (MEM_LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rd             (rd),
        .wr             (wr),
        .hit            (hit),
        .valid          (valid),
        .dirty          (dirty),
        .cache_err      (cache_err),
        .mem_err        (mem_err),
        .mem_stall      (mem_stall),
        .comp           (comp),
        .cache_wr       (cache_wr),
        .way_sel        (way_sel),
        .word_sel       (word_sel),
        .set_valid      (set_valid),
        .use_victim_tag (use_victim_tag),
        .mem_wr         (mem_wr),
        .mem_rd         (mem_rd),
        .mem_word       (mem_word),
        .done           (done),
        .cache_hit      (cache_hit),
        .stall          (stall),
        .err            (err)
`ifdef CACHE_PERF_CNT_EN
        ,
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt),
        .wb_cnt         (wb_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic hit;
        logic err;
        int   cyc;
        logic way;
        logic chk_way;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] outs();
        return {17'b0, comp, cache_wr, way_sel, word_sel, set_valid, use_victim_tag,
                mem_wr, mem_rd, mem_word, done, cache_hit, stall, err};
    endfunction

    // Completion monitor: every done must match the oldest expected result
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("done_hit", cache_hit, e.hit);
                chk("done_err", err, e.err);
                if (e.chk_way) chk("done_way", way_sel, e.way);
            end
        end
    end

    // Single-cycle lookup: hit or error in IDLE
    task automatic run_hit(input logic w, input logic [1:0] h, input logic [1:0] v,
                           input logic ce, input logic way);
        @(posedge clk); #1;
        rd = !w; wr = w; hit = h; valid = v; dirty = 2'b00; cache_err = ce;
        exp_q.push_back('{hit: !ce, err: ce, cyc: cyc, way: way, chk_way: !ce});
        @(negedge clk);
        chk("hit_done", done, 1);
        chk("hit_comp", comp, 1);
        chk("hit_cwr", cache_wr, w && !ce);
        chk("hit_stall", stall, 0);
        @(posedge clk); #1;
        rd = 0; wr = 0; cache_err = 0;
    endtask

    // Miss with optional write-back; s = stall cycles on the first WB word
    task automatic run_miss(input logic w, input logic [1:0] v, input logic [1:0] d,
                            input logic vic, input bit wb, input int s);
        int f, c0, n;
        logic e_wr, e_rd, e_cwr;
        f = wb ? 1 + WORDS + s : 1;
        n = f + MEM_LAT + WORDS;
        @(posedge clk); #1;
        rd = !w; wr = w; hit = 2'b00; valid = v; dirty = d; mem_stall = 0;
        c0 = cyc;
        exp_q.push_back('{hit: 1'b0, err: 1'b0, cyc: c0 + n, way: vic, chk_way: 1'b1});
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                mem_stall = wb && (k >= 1) && (k <= s);
            end
            @(negedge clk);
            e_wr  = wb && (k >= 1) && (k < f);
            e_rd  = (k >= f) && (k < f + WORDS);
            e_cwr = (k >= f + MEM_LAT) && (k < f + MEM_LAT + WORDS);
            chk("stall", stall, k > 0);
            chk("mem_wr", mem_wr, e_wr);
            chk("victim_tag", use_victim_tag, e_wr);
            chk("mem_rd", mem_rd, e_rd);
            chk("cache_wr", cache_wr, e_cwr);
            chk("set_valid", set_valid, k == f + MEM_LAT + WORDS - 1);
            if (e_wr) begin
                chk("wb_word", mem_word, (k <= 1 + s) ? 0 : k - 1 - s);
                chk("wb_way", way_sel, vic);
                chk("wb_comp", comp, 0);
            end
            if (e_rd) chk("rd_word", mem_word, k - f);
            if (e_cwr) begin
                chk("fill_word", word_sel, k - f - MEM_LAT);
                chk("fill_way", way_sel, vic);
            end
        end
        @(posedge clk); #1;
        mem_stall = 0;
        @(negedge clk);
        chk("fin_done", done, 1);
        chk("fin_comp", comp, 1);
        chk("fin_cwr", cache_wr, w);
        chk("fin_stall", stall, 0);
        @(posedge clk); #1;
        rd = 0; wr = 0;
    endtask

    // Memory error during the fill aborts through ERR
    task automatic run_err_fill();
        int c0;
        @(posedge clk); #1;
        rd = 1; wr = 0; hit = 2'b00; valid = 2'b01; dirty = 2'b00;
        c0 = cyc;
        exp_q.push_back('{hit: 1'b0, err: 1'b1, cyc: c0 + 3, way: 1'b0, chk_way: 1'b0});
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_err = 1;
        @(negedge clk);
        chk("efill_err", err, 0);
        chk("efill_done", done, 0);
        @(posedge clk); #1;
        mem_err = 0;
        @(negedge clk);
        chk("err_done", done, 1);
        chk("err_cwr", cache_wr, 0);
        chk("err_stall", stall, 1);
        @(posedge clk); #1;
        rd = 0;
        @(negedge clk);
        chk("err_idle", outs(), 0);
    endtask

    // Reset in the middle of a write-back abandons it
    task automatic run_rst_wb();
        @(posedge clk); #1;
        rd = 0; wr = 1; hit = 2'b00; valid = 2'b11; dirty = 2'b11;
        @(posedge clk); #1;
        @(negedge clk);
        chk("wb_pre_rst", mem_wr, 1);
        #2;
        wr = 0; rst = 1;
        #1;
        chk("rst_mid_outs", outs(), 0);
        @(posedge clk); #1;
        rst = 0;
    endtask

    initial begin
        rst = 1; rd = 0; wr = 0; hit = 0; valid = 0; dirty = 0;
        cache_err = 0; mem_err = 0; mem_stall = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", outs(), 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("idle_outs", outs(), 0);

        run_hit(0, 2'b10, 2'b11, 0, 1'b1);
        run_hit(1, 2'b11, 2'b11, 0, 1'b0);
        run_hit(1, 2'b01, 2'b11, 1, 1'b0);
        run_miss(1, 2'b11, 2'b11, 1'b0, 1, 0);
        run_miss(0, 2'b11, 2'b10, 1'b1, 1, 2);
        run_miss(0, 2'b01, 2'b00, 1'b1, 0, 0);
        run_err_fill();
        run_hit(0, 2'b01, 2'b01, 0, 1'b0);
        run_rst_wb();
        run_miss(0, 2'b11, 2'b00, 1'b0, 0, 0);
        run_miss(0, 2'b11, 2'b00, 1'b1, 0, 0);

        repeat (2) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
